div_unit: RTL and testbench

- Iterative radix-2 restoring divider implementing the RV32M DIV, DIVU, REM and REMU operations.
- Sits beside alu in the execute stage. alu covers single-cycle arithmetic; div_unit covers the long-latency ops, and the pipeline stalls while it is busy.
- Operands and result are 32-bit and use the same src1/src2/result naming as the ALU datapath. A start/busy/done handshake replaces the ALU's combinational timing.

---
 rtl/div_unit.sv | 135 +++++++++++++
 tb/tb_div_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish without iterating.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              busy_d, done_d;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   divisor_q, rem_q, quo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_quo_q, neg_rem_q;

  logic              is_signed_c, is_rem_c, s1_neg_c, s2_neg_c;
  logic [XLEN-1:0]   mag1_c, mag2_c;
  logic              div_zero_c, overflow_c, special_c, accept_c, last_step_c;
  logic [XLEN-1:0]   special_res_c;
  logic [XLEN:0]     rem_ext_c, trial_c;
  logic [XLEN-1:0]   rem_nx_c, quo_nx_c, result_fix_c;

  // Operand conditioning for a request arriving in IDLE
  always_comb begin
    is_signed_c   = ~op[0];
    is_rem_c      = op[1];
    s1_neg_c      = src1[XLEN-1];
    s2_neg_c      = src2[XLEN-1];
    mag1_c        = (is_signed_c && s1_neg_c) ? (XLEN'(0) - src1) : src1;
    mag2_c        = (is_signed_c && s2_neg_c) ? (XLEN'(0) - src2) : src2;
    div_zero_c    = (src2 == '0);
    overflow_c    = is_signed_c && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    special_c     = div_zero_c || overflow_c;
    accept_c      = (state_q == IDLE) && start && !kill;
    special_res_c = '0;
    if (div_zero_c)
      special_res_c = is_rem_c ? src1 : '1;
    else if (!is_rem_c)
      special_res_c = src1;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor
  always_comb begin
    rem_ext_c   = {rem_q, quo_q[XLEN-1]};
    trial_c     = rem_ext_c - {1'b0, divisor_q};
    quo_nx_c    = {quo_q[XLEN-2:0], ~trial_c[XLEN]};
    rem_nx_c    = trial_c[XLEN] ? rem_ext_c[XLEN-1:0] : trial_c[XLEN-1:0];
    last_step_c = (cnt_q == CNT_W'(XLEN - 1));
    case (op_q)
      OP_DIV:  result_fix_c = neg_quo_q ? (XLEN'(0) - quo_nx_c) : quo_nx_c;
      OP_DIVU: result_fix_c = quo_nx_c;
      OP_REM:  result_fix_c = neg_rem_q ? (XLEN'(0) - rem_nx_c) : rem_nx_c;
      default: result_fix_c = rem_nx_c;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = special_c ? DONE : CALC;
      CALC: begin
        if (kill)             state_d = IDLE;
        else if (last_step_c) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs follow the state being entered
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d == CALC) busy_d = 1'b1;
    if (state_d == DONE) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Datapath; result only moves when a new operation completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result    <= '0;
    end else if (accept_c) begin
      op_q      <= op;
      divisor_q <= mag2_c;
      rem_q     <= '0;
      quo_q     <= mag1_c;
      cnt_q     <= '0;
      neg_quo_q <= s1_neg_c ^ s2_neg_c;
      neg_rem_q <= s1_neg_c;
      if (special_c) result <= special_res_c;
    end else if (state_q == CALC && !kill) begin
      rem_q <= rem_nx_c;
      quo_q <= quo_nx_c;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_step_c) result <= result_fix_c;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results from a
// behavioural model, plus handshake timing, kill, reset and start-hold scenarios.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, kill, busy, done;
  logic [1:0]  op;
  logic [31:0] src1, src2, result;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src1(src1), .src2(src2),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src1 = a; src2 = b;
    exp_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); src1 = $urandom; src2 = $urandom;
  endtask

  task automatic wait_done(output bit got, output int cyc, output int busy_cyc, output bit overlap);
    got = 1'b0; cyc = 0; busy_cyc = 0; overlap = 1'b0;
    while (cyc < 100) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin got = 1'b1; break; end
      if (busy) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (result !== 32'd0) $display("FAIL reset_result got=%h exp=0", result); else n_pass++;
    rst_n = 1'b1;
    last_res = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [1:0]  ops[2] = '{2'b01, 2'b11};
    logic [31:0] want[2] = '{32'd14, 32'd2};
    bit got, ovl; int cyc, bcyc; logic [31:0] e;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 32'd100, 32'd7);
      wait_done(got, cyc, bcyc, ovl);
      e = exp_q.pop_front();
      n_checks++; if (!got || result !== want[i] || e !== want[i])
        $display("FAIL unsigned_%0d got=%h done=%b exp=%h", i, result, got, want[i]); else n_pass++;
      n_checks++; if (cyc != 32 || bcyc != 32 || ovl)
        $display("FAIL unsigned_timing_%0d latency=%0d busy_cycles=%0d overlap=%b exp=32/32/0", i, cyc, bcyc, ovl); else n_pass++;
      last_res = want[i];
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0 || result !== want[i])
        $display("FAIL unsigned_hold_%0d done=%b busy=%b result=%h exp=0/0/%h", i, done, busy, result, want[i]); else n_pass++;
    end
  endtask

  task automatic test_signed();
    logic [1:0]  ops[3] = '{2'b00, 2'b10, 2'b00};
    logic [31:0] a[3]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] b[3]   = '{32'd2, 32'd2, 32'hFFFF_FFFE};
    logic [31:0] want[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3};
    bit got, ovl; int cyc, bcyc; logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], a[i], b[i]);
      wait_done(got, cyc, bcyc, ovl);
      e = exp_q.pop_front();
      n_checks++; if (!got || result !== want[i] || e !== want[i] || cyc != 32)
        $display("FAIL signed_%0d got=%h done=%b latency=%0d exp=%h/32", i, result, got, cyc, want[i]); else n_pass++;
      last_res = want[i];
      @(negedge clk);
    end
  endtask

  task automatic test_special();
    logic [1:0]  ops[4] = '{2'b01, 2'b10, 2'b00, 2'b10};
    logic [31:0] a[4]   = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b[4]   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] want[4] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0};
    bit got, ovl; int cyc, bcyc; logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], a[i], b[i]);
      wait_done(got, cyc, bcyc, ovl);
      e = exp_q.pop_front();
      n_checks++; if (!got || result !== want[i] || e !== want[i])
        $display("FAIL special_%0d got=%h done=%b exp=%h", i, result, got, want[i]); else n_pass++;
      n_checks++; if (cyc != 0 || bcyc != 0 || ovl)
        $display("FAIL special_timing_%0d latency=%0d busy_cycles=%0d exp=0/0", i, cyc, bcyc); else n_pass++;
      last_res = want[i];
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL special_after_%0d done=%b busy=%b exp=0/0", i, done, busy); else n_pass++;
    end
  endtask

  task automatic test_kill();
    bit got, ovl; int cyc, bcyc; logic [31:0] e; bit saw_done;
    issue(2'b01, 32'd1000, 32'd3);
    void'(exp_q.pop_back());
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== last_res)
      $display("FAIL kill_calc busy=%b done=%b result=%h exp=0/0/%h", busy, done, result, last_res); else n_pass++;
    issue(2'b01, 32'd1001, 32'd10);
    wait_done(got, cyc, bcyc, ovl);
    e = exp_q.pop_front();
    n_checks++; if (!got || result !== 32'd100 || e !== 32'd100 || cyc != 32)
      $display("FAIL kill_restart got=%h done=%b latency=%0d exp=00000064/32", result, got, cyc); else n_pass++;
    last_res = 32'd100;
    @(negedge clk);
    // kill in IDLE must block a simultaneous start
    start = 1'b1; kill = 1'b1; op = 2'b01; src1 = 32'd50; src2 = 32'd5;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy || done) saw_done = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (saw_done || result !== last_res)
      $display("FAIL kill_idle activity=%b result=%h exp=0/%h", saw_done, result, last_res); else n_pass++;
  endtask

  task automatic test_start_held();
    bit got, ovl; int cyc, bcyc; logic [31:0] e;
    issue(2'b01, 32'hFFFF_FFFF, 32'h10);
    start = 1'b1; op = 2'b00; src1 = 32'd5; src2 = 32'd1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_done(got, cyc, bcyc, ovl);
    e = exp_q.pop_front();
    n_checks++; if (!got || result !== 32'h0FFF_FFFF || e !== 32'h0FFF_FFFF || cyc != 12)
      $display("FAIL start_held got=%h done=%b latency=%0d exp=0fffffff/12", result, got, cyc); else n_pass++;
    last_res = 32'h0FFF_FFFF;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL start_held_after busy=%b done=%b exp=0/0", busy, done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit act;
    issue(2'b11, 32'd12345, 32'd17);
    void'(exp_q.pop_back());
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0)
      $display("FAIL reset_mid busy=%b done=%b result=%h exp=0/0/0", busy, done, result); else n_pass++;
    last_res = 32'd0;
    act = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy || done) act = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (act) $display("FAIL reset_mid_idle activity=%b exp=0", act); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit got, ovl; int cyc, bcyc; logic [31:0] e, a, b; logic [1:0] o;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 3 == 0) b = 32'(0) - b;
      issue(o, a, b);
      wait_done(got, cyc, bcyc, ovl);
      e = exp_q.pop_front();
      n_checks++; if (!got || result !== e || ovl)
        $display("FAIL b2b_%0d op=%0d a=%h b=%h got=%h done=%b exp=%h", i, o, a, b, result, got, e); else n_pass++;
      last_res = e;
      @(negedge clk);
      n_checks++; if (done !== 1'b0)
        $display("FAIL b2b_pulse_%0d done=%b exp=0", i, done); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_kill();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
